// File: rtl/cic_ctrl_pkg.sv
// cic_ctrl_pkg
// Shared types and constants for the CIC decimation-rate controller.
//   ctrl_state_t : controller phase (flush, settle, run)
//   CLR_CNT_W    : clear-counter width for the default CLEAR_CYCLES (4)
//   SET_CNT_W    : settle-counter width for the default STAGES (3)
//   cnt_width()  : counter width for an arbitrary terminal count, never below 1
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        SETTLE,
        RUN
    } ctrl_state_t;

    localparam int DEF_CLEAR_CYCLES = 4;
    localparam int DEF_STAGES       = 3;

    localparam int CLR_CNT_W = $clog2(DEF_CLEAR_CYCLES);
    localparam int SET_CNT_W = $clog2(DEF_STAGES + 1);

    // Width needed to hold the values 0..n-1; never returns less than 1.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cic_rate_ctrl.sv
// cic_rate_ctrl
// Run-time decimation-rate controller for the CIC decimator. It validates
// rate-change requests and flushes the CIC with a clear pulse. It gates the
// CIC input strobe and hides the transient outputs that follow a clear.
// Ports:
//   clock          in  : rising-edge clock
//   reset          in  : asynchronous active-high reset
//   rate_req       in  : requested decimation
//   rate_load      in  : one-cycle request to apply rate_req
//   in_strobe      in  : upstream sample strobe
//   cic_out_strobe in  : CIC output strobe
//   cic_in_strobe  out : gated strobe to the CIC input (combinational)
//   cic_clear      out : registered clear to the CIC
//   decimation     out : registered active rate to the CIC
//   out_valid      out : qualified output strobe (combinational)
//   busy           out : registered, high whenever not in RUN
//   rate_err       out : registered one-cycle pulse on a rejected request
module cic_rate_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int RATE_W       = 8,
    parameter int MIN_RATE     = 2,
    parameter int MAX_RATE     = 255,
    parameter int RESET_RATE   = 16,
    parameter int STAGES       = 3,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [RATE_W-1:0] rate_req,
    input  logic              rate_load,
    input  logic              in_strobe,
    input  logic              cic_out_strobe,
    output logic              cic_in_strobe,
    output logic              cic_clear,
    output logic [RATE_W-1:0] decimation,
    output logic              out_valid,
    output logic              busy,
    output logic              rate_err
);

    localparam int CW = cnt_width(CLEAR_CYCLES);
    localparam int SW = cnt_width(STAGES + 1);

    localparam logic [RATE_W-1:0] MIN_R   = RATE_W'(MIN_RATE);
    localparam logic [RATE_W-1:0] MAX_R   = RATE_W'(MAX_RATE);
    localparam logic [RATE_W-1:0] RESET_R = RATE_W'(RESET_RATE);
    localparam logic [CW-1:0]     CLR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [SW-1:0]     SET_LAST = SW'(STAGES - 1);

    ctrl_state_t       state_q, state_d;
    logic [CW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
    logic [RATE_W-1:0] dec_q, dec_d;
    logic              pend_valid_q, pend_valid_d;
    logic [RATE_W-1:0] pend_rate_q, pend_rate_d;
    logic              rate_err_q;
    logic              cic_clear_q;
    logic              busy_q;

    logic              req_in_range;
    logic              req_ok;
    logic              req_bad;

    assign req_in_range = (rate_req >= MIN_R) && (rate_req <= MAX_R);
    assign req_ok       = rate_load && req_in_range;
    assign req_bad      = rate_load && !req_in_range;

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        settle_cnt_d = settle_cnt_q;
        dec_d        = dec_q;
        pend_valid_d = pend_valid_q;
        pend_rate_d  = pend_rate_q;

        case (state_q)
            CLEAR: begin
                if (req_ok) begin
                    pend_valid_d = 1'b1;
                    pend_rate_d  = rate_req;
                end
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = SETTLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + CW'(1);
                end
            end
            SETTLE: begin
                if (req_ok) begin
                    pend_valid_d = 1'b1;
                    pend_rate_d  = rate_req;
                end
                // The STAGES-th output strobe is itself a transient and is dropped.
                if (cic_out_strobe) begin
                    if (settle_cnt_q == SET_LAST) begin
                        state_d      = RUN;
                        settle_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
            end
            RUN: begin
                // A fresh request supersedes anything left pending from the flush.
                if (req_ok) begin
                    dec_d        = rate_req;
                    pend_valid_d = 1'b0;
                    state_d      = CLEAR;
                end else if (pend_valid_q) begin
                    dec_d        = pend_rate_q;
                    pend_valid_d = 1'b0;
                    state_d      = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            settle_cnt_q <= '0;
            dec_q        <= RESET_R;
            pend_valid_q <= 1'b0;
            pend_rate_q  <= '0;
            rate_err_q   <= 1'b0;
            cic_clear_q  <= 1'b1;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            dec_q        <= dec_d;
            pend_valid_q <= pend_valid_d;
            pend_rate_q  <= pend_rate_d;
            rate_err_q   <= req_bad;
            // Decoded from next state so these leave the flop glitch-free.
            cic_clear_q  <= (state_d == CLEAR);
            busy_q       <= (state_d != RUN);
        end
    end

    assign cic_in_strobe = in_strobe && (state_q != CLEAR);
    // The RUN cycle that only hands a pending rate to CLEAR must not emit a sample.
    assign out_valid     = cic_out_strobe && (state_q == RUN) && !pend_valid_q;
    assign cic_clear     = cic_clear_q;
    assign busy          = busy_q;
    assign decimation    = dec_q;
    assign rate_err      = rate_err_q;

endmodule

// File: tb/tb_cic_rate_ctrl.sv
module tb_cic_rate_ctrl;

    localparam int RATE_W       = 9;
    localparam int MIN_RATE     = 2;
    localparam int MAX_RATE     = 255;
    localparam int RESET_RATE   = 16;
    localparam int STAGES       = 3;
    localparam int CLEAR_CYCLES = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [RATE_W-1:0] rate_req;
    logic              rate_load;
    logic              in_strobe;
    logic              cic_out_strobe;
    logic              cic_in_strobe;
    logic              cic_clear;
    logic [RATE_W-1:0] decimation;
    logic              out_valid;
    logic              busy;
    logic              rate_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining flush cycles, remaining outputs to drop,
    // active rate, one-deep pending request, registered error pulse.
    int m_clear_left;
    int m_discard_left;
    int m_rate;
    bit m_pend;
    int m_pend_rate;
    bit m_err;

    cic_rate_ctrl #(
        .RATE_W      (RATE_W),
        .MIN_RATE    (MIN_RATE),
        .MAX_RATE    (MAX_RATE),
        .RESET_RATE  (RESET_RATE),
        .STAGES      (STAGES),
        .CLEAR_CYCLES(CLEAR_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rate_req      (rate_req),
        .rate_load     (rate_load),
        .in_strobe     (in_strobe),
        .cic_out_strobe(cic_out_strobe),
        .cic_in_strobe (cic_in_strobe),
        .cic_clear     (cic_clear),
        .decimation    (decimation),
        .out_valid     (out_valid),
        .busy          (busy),
        .rate_err      (rate_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_running();
        return (m_clear_left == 0) && (m_discard_left == 0);
    endfunction

    function automatic void model_reset();
        m_clear_left   = CLEAR_CYCLES;
        m_discard_left = STAGES;
        m_rate         = RESET_RATE;
        m_pend         = 1'b0;
        m_pend_rate    = 0;
        m_err          = 1'b0;
    endfunction

    function automatic void model_flush(input int r);
        m_rate         = r;
        m_clear_left   = CLEAR_CYCLES;
        m_discard_left = STAGES;
        m_pend         = 1'b0;
    endfunction

    function automatic void model_step(input bit ld, input int req, input bit cos);
        bit in_range;
        bit ok;
        in_range = (req >= MIN_RATE) && (req <= MAX_RATE);
        ok       = ld && in_range;
        m_err    = ld && !in_range;
        if (m_clear_left > 0) begin
            m_clear_left--;
            if (ok) begin m_pend = 1'b1; m_pend_rate = req; end
        end else if (m_discard_left > 0) begin
            if (cos) m_discard_left--;
            if (ok) begin m_pend = 1'b1; m_pend_rate = req; end
        end else begin
            if (ok) model_flush(req);
            else if (m_pend) model_flush(m_pend_rate);
        end
    endfunction

    // One clock: drive inputs after the falling edge, check, then advance the model.
    task automatic cycle(input bit ld, input int req, input bit ins, input bit cos);
        @(negedge clock);
        rate_load      = ld;
        rate_req       = RATE_W'(req);
        in_strobe      = ins;
        cic_out_strobe = cos;
        #1;
        check_eq("cic_in_strobe", int'(cic_in_strobe), int'(ins && (m_clear_left == 0)));
        check_eq("out_valid", int'(out_valid), int'(cos && m_running() && !m_pend));
        check_eq("cic_clear", int'(cic_clear), int'(m_clear_left > 0));
        check_eq("busy", int'(busy), int'(!m_running()));
        check_eq("decimation", int'(decimation), m_rate);
        check_eq("rate_err", int'(rate_err), int'(m_err));
        @(posedge clock);
        model_step(ld, req, cos);
    endtask

    task automatic run_until_run(input int bound, input int ins_per, input int cos_per);
        for (int i = 0; i < bound; i++) begin
            if (m_running()) return;
            cycle(1'b0, 0, (i % ins_per) == 0, (i % cos_per) == 0);
        end
        if (!m_running()) check_eq("run_timeout", int'(busy), 0);
    endtask

    task automatic run_until_settle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (m_clear_left == 0) return;
            cycle(1'b0, 0, 1'b1, 1'b0);
        end
        if (m_clear_left != 0) check_eq("settle_timeout", int'(cic_clear), 0);
    endtask

    // Asynchronous reset asserted between edges, released just after a rising edge.
    task automatic do_reset();
        @(negedge clock);
        #2;
        rate_load      = 1'b0;
        in_strobe      = 1'b1;
        cic_out_strobe = 1'b1;
        reset          = 1'b1;
        #1;
        check_eq("rst_cic_clear", int'(cic_clear), 1);
        check_eq("rst_busy", int'(busy), 1);
        check_eq("rst_cic_in_strobe", int'(cic_in_strobe), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_rate_err", int'(rate_err), 0);
        check_eq("rst_decimation", int'(decimation), RESET_RATE);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        rate_req       = '0;
        rate_load      = 1'b0;
        in_strobe      = 1'b0;
        cic_out_strobe = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Bring-up: input strobe every 4th cycle, CIC output every 8th.
        run_until_run(200, 4, 8);
        for (int i = 0; i < 16; i++) cycle(1'b0, 0, (i % 4) == 0, (i % 8) == 0);

        // Rate change in RUN, with CIC output strobes pulsed during the flush.
        cycle(1'b1, 8, 1'b0, 1'b0);
        #1;
        check_eq("ld8_decimation", int'(decimation), 8);
        check_eq("ld8_cic_clear", int'(cic_clear), 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b1);
        run_until_run(200, 2, 5);
        cycle(1'b0, 0, 1'b1, 1'b0);

        // Out-of-range requests are rejected without disturbing RUN.
        cycle(1'b1, 1, 1'b1, 1'b0);
        #1;
        check_eq("req1_rate_err", int'(rate_err), 1);
        check_eq("req1_busy", int'(busy), 0);
        check_eq("req1_decimation", int'(decimation), 8);
        cycle(1'b1, 300, 1'b1, 1'b0);
        #1;
        check_eq("req300_rate_err", int'(rate_err), 1);
        check_eq("req300_busy", int'(busy), 0);
        check_eq("req300_decimation", int'(decimation), 8);
        cycle(1'b0, 0, 1'b1, 1'b1);

        // Two requests during SETTLE: only the latest one is applied.
        cycle(1'b1, 8, 1'b1, 1'b0);
        run_until_settle(20);
        cycle(1'b1, 32, 1'b1, 1'b0);
        cycle(1'b1, 64, 1'b1, 1'b0);
        run_until_run(200, 1, 3);
        cycle(1'b0, 0, 1'b1, 1'b1);
        #1;
        check_eq("pend_decimation", int'(decimation), 64);
        check_eq("pend_cic_clear", int'(cic_clear), 1);
        run_until_run(200, 1, 3);

        // Reset mid-SETTLE with rate 8 active and 32 pending.
        cycle(1'b1, 8, 1'b1, 1'b0);
        run_until_settle(20);
        cycle(1'b1, 32, 1'b1, 1'b0);
        do_reset();
        run_until_run(200, 1, 4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, 1'b1);
        #1;
        check_eq("rst_pend_lost", int'(decimation), RESET_RATE);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit ld;
            int req;
            ld  = ($urandom_range(0, 29) == 0);
            req = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                               : int'($urandom_range(0, 20));
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
            end else begin
                cycle(ld, req, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_rate_ctrl.md
# cic_rate_ctrl

Run-time decimation-rate controller for the CIC decimator in the DDC chain. It accepts rate-change requests and validates them. It flushes the CIC with a clear pulse, gates the CIC input strobe, and suppresses the transient outputs that follow a clear. Downstream stages then see only settled samples at the active rate. It sits between the mixer/NCO sample strobe and the CIC, next to the CIC output register.

## Interface
Parameters:
- RATE_W, 8 — width of rate fields.
- MIN_RATE, 2 — smallest accepted decimation.
- MAX_RATE, 255 — largest accepted decimation; must be ≤ 2^RATE_W−1.
- RESET_RATE, 16 — decimation applied after reset.
- STAGES, 3 — CIC stage count; equals the number of outputs discarded after a clear.
- CLEAR_CYCLES, 4 — clock cycles `cic_clear` is held high.

Ports:
- `clock` — in, 1 — single clock; all logic on its rising edge.
- `reset` — in, 1 — asynchronous, active-high.
- `rate_req` — in, RATE_W — requested decimation.
- `rate_load` — in, 1 — one-cycle request to apply `rate_req`.
- `in_strobe` — in, 1 — upstream sample strobe.
- `cic_out_strobe` — in, 1 — CIC output strobe.
- `cic_in_strobe` — out, 1 — gated strobe to the CIC input.
- `cic_clear` — out, 1 — synchronous clear to the CIC integrators, combs and sample counter.
- `decimation` — out, RATE_W — active rate driven to the CIC.
- `out_valid` — out, 1 — qualified output strobe for downstream.
- `busy` — out, 1 — high in every state other than RUN.
- `rate_err` — out, 1 — one-cycle pulse when a request is rejected.

## Operation
- FSM states are CLEAR, SETTLE and RUN.
- CLEAR:
  - `cic_clear`=1 and `cic_in_strobe`=0.
  - The cycle counter counts 0..CLEAR_CYCLES−1; on the last count go to SETTLE.
- SETTLE:
  - `cic_in_strobe`=`in_strobe` and `out_valid`=0.
  - Each `cic_out_strobe` increments `settle_cnt`.
  - When the STAGES-th strobe is seen, go to RUN on the next edge. That strobe is also discarded.
- RUN:
  - `cic_in_strobe`=`in_strobe` and `out_valid`=`cic_out_strobe`.
  - An accepted request or a pending rate goes to CLEAR.
- Request validation (any state): `rate_load` with `rate_req` outside [MIN_RATE, MAX_RATE] pulses `rate_err` the next cycle. The request is otherwise ignored and any pending rate is kept.
- Valid request in RUN: `decimation`←`rate_req` on the same edge that enters CLEAR.
- Valid request in CLEAR or SETTLE:
  - Stored in a one-deep pending register; the latest request wins.
  - The current sequence completes and returns to RUN.
  - The next cycle applies the pending rate and re-enters CLEAR; no `out_valid` is possible in that single RUN cycle.
- A request equal to the current `decimation` is still accepted and still causes a flush.
- Reset (asynchronous):
  - state=CLEAR, counters=0, `decimation`=RESET_RATE, pending cleared.
  - Outputs during reset: `cic_clear`=1, `busy`=1, `cic_in_strobe`=0, `out_valid`=0, `rate_err`=0.
- Reset mid-sequence aborts the sequence and restarts at CLEAR with RESET_RATE; any pending rate is lost.

## Timing
- `cic_in_strobe` and `out_valid` are combinational gates of registered state: zero latency from `in_strobe` and `cic_out_strobe`.
- `cic_clear`, `busy`, `decimation` and `rate_err` are registered.
- Request-to-clear latency:
  - `rate_load` at edge N (state RUN) → `cic_clear`=1 and new `decimation` from edge N+1.
  - `cic_clear` stays high for exactly CLEAR_CYCLES cycles.
- SETTLE duration is data-dependent: STAGES×`decimation` input strobes.
- First `out_valid` is the (STAGES+1)-th `cic_out_strobe` after `cic_clear` falls.
- `rate_load` on the same cycle as the final SETTLE strobe: goes to pending, then the RUN→CLEAR hop follows as described in Operation.
- `cic_out_strobe` during CLEAR is ignored and does not count.
- `in_strobe` arriving every cycle is legal.

## Structure
- Package `cic_ctrl_pkg`:
  - state enum {CLEAR, SETTLE, RUN}.
  - constant `CLR_CNT_W` = clog2(CLEAR_CYCLES).
  - constant `SET_CNT_W` = clog2(STAGES+1).
- No sub-module; single FSM with two small counters, the pending register and a validity comparator.
- The controller drives the existing CIC's strobes, clear and rate inputs; it does not contain the CIC.

## Test plan
- Reset release, `in_strobe` every 4th cycle, RESET_RATE=16, STAGES=3:
  - `cic_clear` high 4 cycles after release.
  - First 3 `cic_out_strobe` suppressed.
  - 4th produces `out_valid`=1; `busy` falls after the 3rd.
- In RUN, `rate_load` with `rate_req`=8:
  - `decimation`=8 and `cic_clear`=1 next edge.
  - `busy` high until 3 outputs are discarded.
- `rate_req`=1, then `rate_req`=300 with RATE_W=9 (MAX_RATE=255):
  - `rate_err` pulse for each.
  - State stays RUN; `decimation` unchanged.
- During SETTLE, `rate_load` 32 then 64 on consecutive cycles:
  - Settle completes.
  - One RUN cycle, then CLEAR with `decimation`=64; 32 is never applied.
- `cic_out_strobe` pulsed during CLEAR: no count, no `out_valid`.
- Assert `reset` mid-SETTLE with `decimation`=8 and a pending 32:
  - Immediate `cic_clear`=1, `decimation`=16.
  - Pending discarded.
